// File: rtl/dmem_arbiter_if.sv
// Signal bundle between dmem_arbiter, its two requesters (A, B) and DataMemory.
// slave = arbiter view, master = requester/memory environment view.
interface dmem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              A_REQ;
  logic              A_WE;
  logic [ADDR_W-1:0] A_ADDR;
  logic [DATA_W-1:0] A_WDATA;
  logic              A_GNT;
  logic              A_RVALID;
  logic [DATA_W-1:0] A_RDATA;

  logic              B_REQ;
  logic              B_WE;
  logic [ADDR_W-1:0] B_ADDR;
  logic [DATA_W-1:0] B_WDATA;
  logic              B_GNT;
  logic              B_RVALID;
  logic [DATA_W-1:0] B_RDATA;

  logic              MEM_WRITE_ENABLE;
  logic              MEM_READ_ENABLE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_DATA_IN;
  logic [DATA_W-1:0] MEM_DATA_OUT;
  logic              BUSY;

  modport slave (
    input  A_REQ, A_WE, A_ADDR, A_WDATA,
    input  B_REQ, B_WE, B_ADDR, B_WDATA,
    input  MEM_DATA_OUT,
    output A_GNT, A_RVALID, A_RDATA,
    output B_GNT, B_RVALID, B_RDATA,
    output MEM_WRITE_ENABLE, MEM_READ_ENABLE, MEM_ADDRESS, MEM_DATA_IN, BUSY
  );

  modport master (
    output A_REQ, A_WE, A_ADDR, A_WDATA,
    output B_REQ, B_WE, B_ADDR, B_WDATA,
    output MEM_DATA_OUT,
    input  A_GNT, A_RVALID, A_RDATA,
    input  B_GNT, B_RVALID, B_RDATA,
    input  MEM_WRITE_ENABLE, MEM_READ_ENABLE, MEM_ADDRESS, MEM_DATA_IN, BUSY
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-ported DataMemory, one command in flight.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module dmem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 0
) (
  input  logic          CLK,
  input  logic          RST,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  state_t            state, state_next;
  port_t             owner, winner;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [1:0]        wait_cnt;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              any_req, rd_capture;

  assign any_req = bus.A_REQ | bus.B_REQ;

`ifdef DMEM_ARB_RR_EN
  port_t rr_ptr;

  // A lone requester wins outright; the pointer only breaks ties.
  assign winner = (bus.B_REQ && (!bus.A_REQ || rr_ptr == PORT_B)) ? PORT_B : PORT_A;

  always_ff @(posedge CLK) begin
    if (RST)                         rr_ptr <= PORT_A;
    else if (state == IDLE && any_req) rr_ptr <= (winner == PORT_A) ? PORT_B : PORT_A;
  end
`else
  assign winner = (bus.B_REQ && !bus.A_REQ) ? PORT_B : PORT_A;
`endif

  assign rd_capture = !cmd_we &&
                      ((state == ACCESS && RD_LAT == 0) ||
                       (state == WAIT && wait_cnt == LAST_WAIT));

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default every output of a combinational block first so no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (cmd_we)           state_next = IDLE;
               else if (RD_LAT == 0) state_next = RESP;
               else                  state_next = WAIT;
      WAIT:    if (wait_cnt == LAST_WAIT) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command capture and read-return registers; RST clears them because they are visible on ports.
  always_ff @(posedge CLK) begin
    if (RST) begin
      owner     <= PORT_A;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      wait_cnt  <= '0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner     <= winner;
        cmd_we    <= (winner == PORT_B) ? bus.B_WE    : bus.A_WE;
        cmd_addr  <= (winner == PORT_B) ? bus.B_ADDR  : bus.A_ADDR;
        cmd_wdata <= (winner == PORT_B) ? bus.B_WDATA : bus.A_WDATA;
      end
      wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
      if (rd_capture) begin
        if (owner == PORT_B) b_rdata <= bus.MEM_DATA_OUT;
        else                 a_rdata <= bus.MEM_DATA_OUT;
      end
    end
  end

  always_comb begin
    bus.A_GNT            = 1'b0;
    bus.B_GNT            = 1'b0;
    bus.A_RVALID         = 1'b0;
    bus.B_RVALID         = 1'b0;
    bus.MEM_WRITE_ENABLE = 1'b0;
    bus.MEM_READ_ENABLE  = 1'b0;
    case (state)
      ACCESS: begin
        bus.A_GNT            = (owner == PORT_A);
        bus.B_GNT            = (owner == PORT_B);
        bus.MEM_WRITE_ENABLE = cmd_we;
        bus.MEM_READ_ENABLE  = !cmd_we;
      end
      WAIT: bus.MEM_READ_ENABLE = 1'b1;
      RESP: begin
        bus.A_RVALID = (owner == PORT_A);
        bus.B_RVALID = (owner == PORT_B);
      end
      default: ;
    endcase
  end

  assign bus.BUSY        = (state != IDLE);
  assign bus.MEM_ADDRESS = cmd_addr;
  assign bus.MEM_DATA_IN = cmd_wdata;
  assign bus.A_RDATA     = a_rdata;
  assign bus.B_RDATA     = b_rdata;
endmodule
